// File: rtl/dm_sized_hs.sv
// Data memory with byte/half/word access, sign/zero-extended loads and a
// req/ready/done handshake with WAIT_CYC busy cycles per access.
module dm_sized_hs #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic              ready,
  output logic              done,
  output logic [31:0]       dout,
  output logic              err
);

  localparam int unsigned Depth = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, uns_q, err_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         din_q, dout_q;
  logic [31:0]         mem [Depth];

  logic                accept, commit;
  logic                a_we, a_uns, a_err;
  logic [1:0]          a_size;
  logic [ADDR_W-1:0]   a_addr;
  logic [31:0]         a_din;
  logic [ADDR_W-3:0]   idx;
  logic [3:0]          be;
  logic [31:0]         wdata, rword, ldata;
  logic [7:0]          rbyte;
  logic [15:0]         rhalf;

  // With WAIT_CYC=0 the commit happens on the accept edge, so the live inputs
  // are used in IDLE and the latched copies afterwards.
  always_comb begin
    if (state_q == StIdle) begin
      a_we   = we;
      a_size = size;
      a_uns  = uns;
      a_addr = addr;
      a_din  = din;
    end else begin
      a_we   = we_q;
      a_size = size_q;
      a_uns  = uns_q;
      a_addr = addr_q;
      a_din  = din_q;
    end
  end

  assign a_err = (a_size == 2'b11) ||
                 ((a_size == 2'b01) && a_addr[0]) ||
                 ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
  assign idx   = a_addr[ADDR_W-1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYC == 0) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = 4'(WAIT_CYC);
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign commit = (state_d == StResp) && !rst;

  always_comb begin
    be    = 4'b0000;
    wdata = a_din;
    case (a_size)
      2'b00: begin
        be    = 4'b0001 << a_addr[1:0];
        wdata = {4{a_din[7:0]}};
      end
      2'b01: begin
        be    = a_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{a_din[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign rword = mem[idx];
  assign rbyte = rword[{a_addr[1:0], 3'b000} +: 8];
  assign rhalf = rword[{a_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (a_size)
      2'b00:   ldata = a_uns ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   ldata = a_uns ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: ldata = rword;
    endcase
  end

  // Array has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (commit && a_we && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= we;
        size_q <= size;
        uns_q  <= uns;
        addr_q <= addr;
        din_q  <= din;
      end
      if (commit) begin
        err_q <= a_err;
        if (!a_we && !a_err) dout_q <= ldata;
      end
    end
  end

  assign ready = (state_q == StIdle);
  assign done  = (state_q == StResp);
  assign err   = done && err_q;
  assign dout  = dout_q;

endmodule
